mem_port_arbiter: RTL and testbench

- Sequences a single shared data-memory port between the two M-stage lanes of the dual-issue pipeline.
- Inputs are the registered outputs of the two EXE/MEM pipeline registers (lane 0 older in program order).
- Freezes the pipeline through pipe_enable until every memory op in the current M-stage pair is served, lane 0 before lane 1.
- Returns load data per lane.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the two M-stage lanes, lane 0 first, freezing the pipe meanwhile.
// Optional request timeout with sticky mem_err: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    mem_ctrl_m0,
   input  logic [AW-1:0] aluout_m0,
   input  logic [DW-1:0] writedata_m0,
   input  logic [3:0]    mem_ctrl_m1,
   input  logic [AW-1:0] aluout_m1,
   input  logic [DW-1:0] writedata_m1,
   output logic          pipe_enable,
   output logic          mem_req,
   output logic          mem_we,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          rdata_valid,
   output logic          mem_err,
   output logic [1:0]    dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ0 = 2'd1,
      REQ1 = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          need0, need1;
   logic          timeout_hit;

   assign need0 = mem_ctrl_m0[0] | mem_ctrl_m0[1];
   assign need1 = mem_ctrl_m1[0] | mem_ctrl_m1[1];

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   // Counter runs only while a request waits; any ack or state change restarts it.
   always_comb begin
      timeout_hit = ((state_q == REQ0) || (state_q == REQ1)) && !mem_ack && (cnt_q == TO_LIM);
      cnt_d       = 8'd0;
      err_d       = err_q | timeout_hit;
      if (((state_q == REQ0) || (state_q == REQ1)) && !mem_ack && !timeout_hit)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (need0) begin
               state_d = REQ0;
               req_d   = 1'b1;
               we_d    = mem_ctrl_m0[1];
               size_d  = mem_ctrl_m0[3:2];
               addr_d  = aluout_m0;
               wdata_d = writedata_m0;
            end else if (need1) begin
               state_d = REQ1;
               req_d   = 1'b1;
               we_d    = mem_ctrl_m1[1];
               size_d  = mem_ctrl_m1[3:2];
               addr_d  = aluout_m1;
               wdata_d = writedata_m1;
            end
         end
         REQ0: begin
            if (mem_ack) begin
               if (!we_q) rdata0_d = mem_rdata;
               if (need1) begin
                  state_d = REQ1;
                  we_d    = mem_ctrl_m1[1];
                  size_d  = mem_ctrl_m1[3:2];
                  addr_d  = aluout_m1;
                  wdata_d = writedata_m1;
               end else begin
                  state_d = DONE;
                  req_d   = 1'b0;
               end
            end else if (timeout_hit) begin
               state_d = DONE;
               req_d   = 1'b0;
            end
         end
         REQ1: begin
            if (mem_ack) begin
               if (!we_q) rdata1_d = mem_rdata;
               state_d = DONE;
               req_d   = 1'b0;
            end else if (timeout_hit) begin
               state_d = DONE;
               req_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         req_q    <= req_d;
         we_q     <= we_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      pipe_enable = (state_q == DONE) || ((state_q == IDLE) && !need0 && !need1);
      rdata_valid = (state_q == DONE);
   end

   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_size    = size_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transfers and DONE results are queued by the
// stimulus and checked by a negedge monitor that also models the memory.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    mem_ctrl_m0, mem_ctrl_m1;
  logic [AW-1:0] aluout_m0, aluout_m1;
  logic [DW-1:0] writedata_m0, writedata_m1;
  logic          pipe_enable, mem_req, mem_we, mem_ack, rdata_valid, mem_err;
  logic [1:0]    mem_size, dbg_state;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata0, rdata1;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .mem_ctrl_m0(mem_ctrl_m0), .aluout_m0(aluout_m0), .writedata_m0(writedata_m0),
    .mem_ctrl_m1(mem_ctrl_m1), .aluout_m1(aluout_m1), .writedata_m1(writedata_m1),
    .pipe_enable(pipe_enable), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata0(rdata0), .rdata1(rdata1), .rdata_valid(rdata_valid), .mem_err(mem_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [66:0] exp_xfer_q[$];  // {we, size, addr, wdata}
  logic [63:0] exp_done_q[$];  // {rdata0, rdata1}
  logic [31:0] mem_model [logic [31:0]];
  int wait_states = 0;
  bit ack_en = 1'b1;
  int wcnt = 0;
  int req_cycles = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model + monitor
  always @(negedge clk) begin : mon
    logic [66:0] ex;
    logic [63:0] ed;
    if (mem_req) req_cycles++;
    if (rdata_valid) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: rdata_valid with empty queue");
      end else begin
        ed = exp_done_q.pop_front();
        check("done_rdata", {3'b0, rdata0, rdata1}, {3'b0, ed});
      end
    end
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (ack_en && wcnt == wait_states) begin
      if (exp_xfer_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: transfer addr %h with empty queue", mem_addr);
      end else begin
        ex = exp_xfer_q.pop_front();
        check("xfer_fields", {mem_we, mem_size, mem_addr, mem_wdata}, ex);
      end
      mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      mem_ack = 1'b1;
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  task automatic drive(input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] d1);
    mem_ctrl_m0 = c0; aluout_m0 = a0; writedata_m0 = d0;
    mem_ctrl_m1 = c1; aluout_m1 = a1; writedata_m1 = d1;
  endtask

  // driver: present a lane pair, wait for the advancing cycle, check freeze length and req cycles
  task automatic run_pair(input string name,
                          input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                          input int exp_low, input int exp_req);
    int low;
    @(negedge clk);
    drive(c0, a0, d0, c1, a1, d1);
    req_cycles = 0;
    low = 0;
    #1;
    while (!pipe_enable && low < 100) begin
      low++;
      @(negedge clk);
      #1;
    end
    check({name, "_pipe_low"}, 67'(low), 67'(exp_low));
    check({name, "_req_cycles"}, 67'(req_cycles), 67'(exp_req));
    @(posedge clk);
    #1;
    drive(4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    mem_model[32'h100] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle: no ops for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_pipe_enable", 67'(pipe_enable), 67'd1);
      check("idle_mem_req", 67'(mem_req), 67'd0);
      check("idle_req_fields", {mem_we, mem_size, mem_addr, mem_wdata}, 67'd0);
      check("idle_results", 67'({rdata0, rdata1, rdata_valid, mem_err}), 67'd0);
      check("idle_state", 67'(dbg_state), 67'd0);
    end

    // lane 0 word read, zero wait
    wait_states = 0;
    exp_xfer_q.push_back({1'b0, 2'b10, 32'h100, 32'h0});
    exp_done_q.push_back({32'hDEADBEEF, 32'h0});
    run_pair("rd0", 4'b1001, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 2, 1);

    // lane 0 store then lane 1 load same address, 2 wait states
    wait_states = 2;
    exp_xfer_q.push_back({1'b1, 2'b10, 32'h200, 32'h11});
    exp_xfer_q.push_back({1'b0, 2'b10, 32'h200, 32'h0});
    exp_done_q.push_back({32'hDEADBEEF, 32'h11});
    run_pair("st_ld", 4'b1010, 32'h200, 32'h11, 4'b1001, 32'h200, 32'h0, 7, 6);

    // lane 1 only byte store
    wait_states = 0;
    exp_xfer_q.push_back({1'b1, 2'b00, 32'h3, 32'hAB});
    exp_done_q.push_back({32'hDEADBEEF, 32'h11});
    run_pair("l1_byte", 4'h0, 32'h0, 32'h0, 4'b0010, 32'h3, 32'hAB, 2, 1);

    // same-address store/store, zero wait dual
    exp_xfer_q.push_back({1'b1, 2'b10, 32'h40, 32'h55});
    exp_xfer_q.push_back({1'b1, 2'b10, 32'h40, 32'h66});
    exp_done_q.push_back({32'hDEADBEEF, 32'h11});
    run_pair("st_st", 4'b1010, 32'h40, 32'h55, 4'b1010, 32'h40, 32'h66, 3, 2);

    // read+write bits both set acts as store; lane 1 half load sees it
    exp_xfer_q.push_back({1'b1, 2'b10, 32'h50, 32'h77});
    exp_xfer_q.push_back({1'b0, 2'b01, 32'h50, 32'h0});
    exp_done_q.push_back({32'hDEADBEEF, 32'h77});
    run_pair("both_bits", 4'b1011, 32'h50, 32'h77, 4'b0101, 32'h50, 32'h0, 3, 2);

    // read back the store/store location with one wait state
    wait_states = 1;
    exp_xfer_q.push_back({1'b0, 2'b10, 32'h40, 32'h0});
    exp_done_q.push_back({32'h66, 32'h77});
    run_pair("rd_back", 4'b1001, 32'h40, 32'h0, 4'h0, 32'h0, 32'h0, 3, 2);

    // reset during REQ1 with ack withheld
    wait_states = 0;
    ack_en = 1'b0;
    @(negedge clk);
    drive(4'h0, 32'h0, 32'h0, 4'b1001, 32'h300, 32'h0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", 67'(mem_req), 67'd1);
    check("rst_in_req1", 67'(dbg_state), 67'd2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_req", 67'(mem_req), 67'd0);
    check("rst_state", 67'(dbg_state), 67'd0);
    check("rst_rdata", 67'({rdata0, rdata1}), 67'd0);
    drive(4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;

    exp_xfer_q.push_back({1'b0, 2'b10, 32'h100, 32'h0});
    exp_done_q.push_back({32'hDEADBEEF, 32'h0});
    run_pair("post_rst", 4'b1001, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 2, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // ack never comes: abort after 4 waits, lane 1 skipped, rdata untouched
    ack_en = 1'b0;
    exp_done_q.push_back({32'hDEADBEEF, 32'h0});
    run_pair("timeout", 4'b1001, 32'h100, 32'h0, 4'b1001, 32'h200, 32'h0, 5, 4);
    check("timeout_err", 67'(mem_err), 67'd1);
    repeat (3) @(negedge clk);
    #1;
    check("timeout_err_sticky", 67'(mem_err), 67'd1);
    check("timeout_idle_req", 67'(mem_req), 67'd0);
    ack_en = 1'b1;
`else
    check("no_timeout_err", 67'(mem_err), 67'd0);
`endif

    repeat (2) @(negedge clk);
    check("xfer_queue_empty", 67'(exp_xfer_q.size()), 67'd0);
    check("done_queue_empty", 67'(exp_done_q.size()), 67'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
